// File: rtl/branch_pkg.sv
// Shared definitions for the branch control unit: FSM states, opcode
// classes, PC/immediate select encodings, condition codes, helpers.
package branch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EX0,
        S_EX1,
        S_ERR
    } state_t;

    // Opcode classes in IR[31:29]
    localparam logic [2:0] CL_B     = 3'b000;
    localparam logic [2:0] CL_BCOND = 3'b010;
    localparam logic [2:0] CL_BL    = 3'b100;
    localparam logic [2:0] CL_CB    = 3'b101;
    localparam logic [2:0] CL_BR    = 3'b110;

    // CB sub-op in IR[25:24]
    localparam logic [1:0] CB_Z  = 2'b00;
    localparam logic [1:0] CB_NZ = 2'b01;

    // PC function select
    localparam logic [1:0] PCFS_HOLD = 2'b00;
    localparam logic [1:0] PCFS_INC  = 2'b01;
    localparam logic [1:0] PCFS_REG  = 2'b10;
    localparam logic [1:0] PCFS_K    = 2'b11;

    // Immediate select
    localparam logic [2:0] KM_NONE   = 3'b000;
    localparam logic [2:0] KM_BR26   = 3'b010;
    localparam logic [2:0] KM_COND19 = 3'b011;

    // Condition codes
    localparam logic [3:0] CC_EQ = 4'd0;
    localparam logic [3:0] CC_NE = 4'd1;
    localparam logic [3:0] CC_CS = 4'd2;
    localparam logic [3:0] CC_CC = 4'd3;
    localparam logic [3:0] CC_MI = 4'd4;
    localparam logic [3:0] CC_PL = 4'd5;
    localparam logic [3:0] CC_VS = 4'd6;
    localparam logic [3:0] CC_VC = 4'd7;
    localparam logic [3:0] CC_HI = 4'd8;
    localparam logic [3:0] CC_LS = 4'd9;
    localparam logic [3:0] CC_GE = 4'd10;
    localparam logic [3:0] CC_LT = 4'd11;
    localparam logic [3:0] CC_GT = 4'd12;
    localparam logic [3:0] CC_LE = 4'd13;

    localparam logic [4:0] FS_OR = 5'b00100;
    localparam logic [1:0] DT_PC = 2'b10;

    // True when the instruction word is a supported branch encoding.
    function automatic logic legal(input logic [31:0] ir);
        logic ok;
        case (ir[31:29])
            CL_B, CL_BCOND, CL_BL, CL_BR: ok = 1'b1;
            CL_CB:                        ok = ~ir[25];
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Packs {FS, SA, SB, DA, low16} with rw-bit register fields into the
    // low bits of a 64-bit word; the caller truncates to its width.
    function automatic logic [63:0] pack_cw(
        input int          rw,
        input logic [4:0]  fs,
        input logic [7:0]  sa,
        input logic [7:0]  sb,
        input logic [7:0]  da,
        input logic [15:0] lo
    );
        logic [63:0] w;
        w = 64'(fs);
        w = (w << rw) | 64'(sa);
        w = (w << rw) | 64'(sb);
        w = (w << rw) | 64'(da);
        w = (w << 16) | 64'(lo);
        return w;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition-code evaluator.
// Ports: cond[3:0] code, status[3:0] flags {V,C,N,Z}, taken result.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] status,
    output logic       taken
);

    logic v, c, n, z;
    assign {v, c, n, z} = status;

    always_comb begin
        taken = 1'b1;
        case (cond)
            CC_EQ:   taken = z;
            CC_NE:   taken = ~z;
            CC_CS:   taken = c;
            CC_CC:   taken = ~c;
            CC_MI:   taken = n;
            CC_PL:   taken = ~n;
            CC_VS:   taken = v;
            CC_VC:   taken = ~v;
            CC_HI:   taken = c & ~z;
            CC_LS:   taken = ~c | z;
            CC_GE:   taken = ~(n ^ v);
            CC_LT:   taken = n ^ v;
            CC_GT:   taken = ~z & ~(n ^ v);
            CC_LE:   taken = z | (n ^ v);
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/cu_branch_seq.sv
// Branch sequencer: runs B/BL/BR/CB/B.cond through EX0/EX1 and drives
// the datapath control word, immediate select and taken counters.
// Ports: clock, reset (async high), start/IR/status/clr_cnt in;
// busy, done, err, k_mux, controlWord, taken_cnt, nottaken_cnt out.
module cu_branch_seq
    import branch_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int LINK_REG = 28,
    parameter int CNT_W    = 16,
    parameter int CW_W     = 4*REG_W+17
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      IR,
    input  logic [3:0]       status,
    input  logic             clr_cnt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       k_mux,
    output logic [CW_W-1:0]  controlWord,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] nottaken_cnt
);

    state_t           state;
    logic [2:0]       cls_q;
    logic             nz_q;
    logic [3:0]       cond_q;
    logic [REG_W-1:0] rt_q;

    logic is_b, is_bl, is_br, is_cb, is_bcond;
    logic active, cnt_en, cond_taken, taken;
    logic [3:0] cond_sel;
    logic [1:0] pc_fs;
    logic w_reg, b_sel, st_ld;
    logic [63:0] cw_full;

    assign is_b     = (cls_q == CL_B);
    assign is_bl    = (cls_q == CL_BL);
    assign is_br    = (cls_q == CL_BR);
    assign is_cb    = (cls_q == CL_CB);
    assign is_bcond = (cls_q == CL_BCOND);

    // CBZ/CBNZ reuse the EQ/NE codes on the flags loaded in EX0.
    assign cond_sel = is_cb ? {3'b000, nz_q} : cond_q;

    branch_cond_eval u_cond (
        .cond   (cond_sel),
        .status (status),
        .taken  (cond_taken)
    );

    assign taken  = is_b | is_bl | is_br | cond_taken;
    assign active = (state == S_EX0) || (state == S_EX1);
    assign cnt_en = (state == S_EX1) || ((state == S_EX0) && is_br);
    assign busy   = (state != S_IDLE);
    assign err    = (state == S_ERR);
    assign done   = cnt_en | err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cls_q        <= '0;
            nz_q         <= 1'b0;
            cond_q       <= '0;
            rt_q         <= '0;
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cls_q  <= IR[31:29];
                        nz_q   <= IR[24];
                        cond_q <= IR[3:0];
                        rt_q   <= IR[REG_W-1:0];
                        state  <= legal(IR) ? S_EX0 : S_ERR;
                    end
                end
                S_EX0:   state <= is_br ? S_IDLE : S_EX1;
                default: state <= S_IDLE;
            endcase

            if (clr_cnt) begin
                taken_cnt    <= '0;
                nottaken_cnt <= '0;
            end else if (cnt_en) begin
                if (taken) begin
                    if (~&taken_cnt)
                        taken_cnt <= taken_cnt + 1'b1;
                end else begin
                    if (~&nottaken_cnt)
                        nottaken_cnt <= nottaken_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        pc_fs = PCFS_HOLD;
        w_reg = 1'b0;
        b_sel = 1'b1;
        st_ld = 1'b0;
        k_mux = KM_NONE;
        case (state)
            S_EX0: begin
                pc_fs = is_br ? PCFS_REG : PCFS_HOLD;
                w_reg = is_bl;
                b_sel = ~is_cb;
                st_ld = is_cb;
            end
            S_EX1:   pc_fs = taken ? PCFS_K : PCFS_INC;
            default: ;
        endcase
        if (active) begin
            unique case (1'b1)
                is_cb | is_bcond: k_mux = KM_COND19;
                is_br:            k_mux = KM_NONE;
                default:          k_mux = KM_BR26;
            endcase
        end
    end

    // The field list is 3*REG_W+21 bits; spare upper bits stay zero.
    assign cw_full = pack_cw(
        REG_W,
        FS_OR,
        8'((1 << REG_W) - 1),
        8'(rt_q),
        8'(LINK_REG),
        {w_reg, 1'b0, 2'b00, b_sel, 1'b0, 1'b0, st_ld,
         2'b00, 1'b0, DT_PC, ~is_br, pc_fs}
    );

    assign controlWord = active ? CW_W'(cw_full) : '0;

endmodule

// File: tb/tb_cu_branch_seq.sv
// Self-checking bench for cu_branch_seq (CNT_W = 2 to reach saturation).
// Vector table plus hand sequences for BR/start, async reset, counters.
module tb_cu_branch_seq;

    localparam int CW = 37;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   IR = '0;
    logic [3:0]    status = '0;
    logic          clr_cnt = 1'b0;
    logic          busy, done, err;
    logic [2:0]    k_mux;
    logic [CW-1:0] controlWord;
    logic [1:0]    taken_cnt, nottaken_cnt;

    int total = 0;
    int bad = 0;
    logic [1:0] tk_m = 2'd0;
    logic [1:0] nt_m = 2'd0;

    cu_branch_seq #(.CNT_W(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .IR           (IR),
        .status       (status),
        .clr_cnt      (clr_cnt),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .k_mux        (k_mux),
        .controlWord  (controlWord),
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [46:0] v;
        string       nm;
    } exp_t;

    typedef struct {
        string       nm;
        logic [31:0] ir;
        logic [3:0]  st;
        logic [2:0]  km;
        logic [1:0]  pf0;
        logic [1:0]  pf1;
        logic        wl;
        logic        cb;
        logic        br;
        logic        tk;
        logic        il;
    } vec_t;

    exp_t q[$];
    vec_t vt[$];

    function automatic logic [36:0] cwx(input logic wl, input logic bs,
                                        input logic sl, input logic ps,
                                        input logic [1:0] pf,
                                        input logic [4:0] rt);
        return {1'b0, 5'b00100, 5'd31, rt, 5'd28, wl, 1'b0, 2'b00, bs,
                1'b0, 1'b0, sl, 2'b00, 1'b0, 2'b10, ps, pf};
    endfunction

    function automatic logic [46:0] pk(input logic b, input logic d,
                                       input logic e, input logic [2:0] km,
                                       input logic [36:0] cw,
                                       input logic [1:0] tk,
                                       input logic [1:0] nt);
        return {b, d, e, km, cw, tk, nt};
    endfunction

    function automatic logic [46:0] outs();
        return {busy, done, err, k_mux, controlWord, taken_cnt, nottaken_cnt};
    endfunction

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, a, x);
        end
    endtask

    task automatic pop_cmp();
        exp_t e;
        e = q.pop_front();
        chk(e.nm, 64'(outs()), 64'(e.v));
    endtask

    task automatic model_cnt(input logic tk);
        if (tk) tk_m = (tk_m == 2'd3) ? 2'd3 : tk_m + 2'd1;
        else    nt_m = (nt_m == 2'd3) ? 2'd3 : nt_m + 2'd1;
    endtask

    task automatic issue(input vec_t v);
        int n;
        @(negedge clock);
        IR = v.ir;
        status = v.st;
        start = 1'b1;
        if (v.il) begin
            q.push_back('{pk(1'b1, 1'b1, 1'b1, 3'b000, '0, tk_m, nt_m),
                          {v.nm, "/err"}});
        end else begin
            q.push_back('{pk(1'b1, v.br, 1'b0, v.km,
                             cwx(v.wl, ~v.cb, v.cb, ~v.br, v.pf0, v.ir[4:0]),
                             tk_m, nt_m), {v.nm, "/ex0"}});
            if (!v.br)
                q.push_back('{pk(1'b1, 1'b1, 1'b0, v.km,
                                 cwx(1'b0, 1'b1, 1'b0, 1'b1, v.pf1, v.ir[4:0]),
                                 tk_m, nt_m), {v.nm, "/ex1"}});
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        IR = 32'hFFFF_FFFF;
        pop_cmp();
        n = 0;
        while (q.size() > 0 && n < 4) begin
            @(posedge clock);
            #1;
            pop_cmp();
            n++;
        end
        if (!v.il) model_cnt(v.tk);
        @(posedge clock);
        #1;
        chk({v.nm, "/idle"}, 64'(outs()),
            64'(pk(1'b0, 1'b0, 1'b0, 3'b000, '0, tk_m, nt_m)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vb;
        vt.push_back('{"bne",  32'h5000_0001, 4'b0001, 3'b011, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"beq",  32'h5000_0000, 4'b0001, 3'b011, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"bl",   32'h8000_0123, 4'b0000, 3'b010, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"b",    32'h0000_0040, 4'b1111, 3'b010, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"cbz1", 32'hA000_0005, 4'b0001, 3'b011, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"cbnz1",32'hA100_0005, 4'b0001, 3'b011, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"cbnz0",32'hA100_0005, 4'b0000, 3'b011, 2'b00, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"cbz0", 32'hA000_0005, 4'b0000, 3'b011, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"br",   32'hC000_0007, 4'b0000, 3'b000, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        vt.push_back('{"bgt",  32'h4000_000C, 4'b1010, 3'b011, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"blt",  32'h4000_000B, 4'b1010, 3'b011, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"bhi",  32'h4000_0008, 4'b0100, 3'b011, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"bls",  32'h4000_0009, 4'b0100, 3'b011, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"bal",  32'h4000_000E, 4'b0000, 3'b011, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"bnv",  32'h4000_000F, 4'b0000, 3'b011, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"bvs",  32'h4000_0006, 4'b1000, 3'b011, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"bmi",  32'h4000_0004, 4'b0000, 3'b011, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"bge",  32'h4000_000A, 4'b1000, 3'b011, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        vt.push_back('{"bcs",  32'h4000_0002, 4'b0100, 3'b011, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        vt.push_back('{"ill7", 32'hE000_0000, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        vt.push_back('{"ill1", 32'h2000_0000, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        vt.push_back('{"ill3", 32'h6000_0000, 4'b0000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        vt.push_back('{"cbx",  32'hA200_0005, 4'b0001, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        vb = vt[3];

        #12;
        chk("reset_hold", 64'(outs()), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("reset_idle", 64'(outs()), 64'(0));

        for (int i = 0; i < vt.size(); i++)
            issue(vt[i]);

        // BR completes in EX0; a start in that cycle must be dropped.
        @(negedge clock);
        IR = 32'hC000_0007;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("br_ex0", 64'({done, k_mux, controlWord[2:0]}),
            64'({1'b1, 3'b000, 1'b0, 2'b10}));
        @(negedge clock);
        IR = 32'h0000_0040;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        model_cnt(1'b1);
        chk("br_start_ignored", 64'({busy, taken_cnt}), 64'({1'b0, tk_m}));
        @(posedge clock);
        #1;
        chk("br_still_idle", 64'(busy), 64'(0));

        // Asynchronous reset in BL EX0.
        @(negedge clock);
        IR = 32'h8000_0000;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("bl_wreg", 64'({busy, controlWord[15]}), 64'(2'b11));
        #2;
        reset = 1'b1;
        #1;
        tk_m = 2'd0;
        nt_m = 2'd0;
        chk("async_reset", 64'(outs()), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("post_reset", 64'(outs()), 64'(0));

        // Saturation and clear-beats-increment.
        @(negedge clock);
        clr_cnt = 1'b1;
        @(posedge clock);
        #1;
        clr_cnt = 1'b0;
        chk("clr_idle", 64'({taken_cnt, nottaken_cnt}), 64'(0));
        for (int i = 0; i < 5; i++)
            issue(vb);
        chk("sat_taken", 64'(taken_cnt), 64'(3));
        @(negedge clock);
        IR = 32'h0000_0040;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        chk("sixth_done", 64'({done, controlWord[1:0]}), 64'(3'b111));
        clr_cnt = 1'b1;
        @(posedge clock);
        #1;
        clr_cnt = 1'b0;
        chk("clr_beats_inc", 64'({busy, taken_cnt, nottaken_cnt}), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cu_branch_seq.md
# cu_branch_seq

Self-sequencing, parametrised branch control unit for the datapath's control-unit set. Accepts a branch-class instruction from the top-level control unit via a start/done handshake and runs its own EX0/EX1 state machine. Emits a packed control word plus the `k_mux` immediate select for each cycle. It supports B, BL, BR, CBZ, CBNZ and B.cond with all 16 condition codes, flags illegal encodings, and keeps saturating taken/not-taken counters.

## Interface

Parameters:
- `REG_W`, default 5: register-address width.
- `LINK_REG`, default 28: destination register written by BL.
- `CNT_W`, default 16: width of each branch counter.
- `CW_W`, default 4*REG_W+17: derived control-word width; 37 at default.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: IR holds a branch-class instruction; sampled only in IDLE.
- `IR` in 32: instruction; captured on accepted `start`.
- `status` in 4: flags {V,C,N,Z}, live from the status register.
- `clr_cnt` in 1: synchronous clear of both counters.
- `busy` out 1: state is not IDLE.
- `done` out 1: final cycle of the instruction.
- `err` out 1: illegal encoding; asserted together with `done`.
- `k_mux` out 3: immediate select.
- `controlWord` out CW_W: {FS[4:0], SA, SB, DA, w_reg, C0, mem_cs[1:0], B_Sel, mem_write_en, IR_load, status_load, size[1:0], add_tri_sel, data_tri_sel[1:0], PC_sel, PC_FS[1:0]}.
- `taken_cnt` out CNT_W: taken-branch count.
- `nottaken_cnt` out CNT_W: not-taken count.

## Operation

- **Class decode** on latched IR[31:29]:
  - 000 B, 010 B.cond, 100 BL, 101 CB, 110 BR.
  - 001, 011 and 111 are illegal.
  - CB with IR[25:24] = 00 is CBZ, = 01 is CBNZ; 1x is illegal.
- **States:** IDLE, EX0, EX1, ERR.
  - IDLE to EX0 on `start`, except an illegal class goes IDLE to ERR.
  - EX0 to IDLE for BR; EX0 to EX1 for all other legal classes.
  - EX1 to IDLE.
  - ERR to IDLE.
- **`PC_FS` encoding:** 00 hold, 01 PC+4, 10 load from register bus, 11 PC+k.
- **`k_mux` encoding:** CB and B.cond give 011; B and BL give 010; BR gives 000. Held constant through EX0/EX1. Value is 000 in IDLE and ERR.
- **Fixed fields in active states:**
  - FS = 00100 (OR); SA = all ones (zero register); SB = IR[REG_W-1:0]; DA = LINK_REG.
  - C0 = 0, mem_cs = 00, mem_write_en = 0, IR_load = 0, size = 00, add_tri_sel = 0, data_tri_sel = 10.
  - PC_sel = 0 for BR, 1 otherwise.
  - B_Sel = 0 only in CB EX0, else 1.
  - w_reg = 1 only in BL EX0.
  - status_load = 1 only in CB EX0.
- **Per class:**
  - B: EX0 holds the PC; EX1 drives PC_FS = 11.
  - BL: EX0 writes the link register and holds the PC; EX1 drives PC_FS = 11.
  - BR: EX0 drives PC_FS = 10 with `done`.
  - CBZ / CBNZ: EX0 runs OR(XZR, Rt) and loads flags; EX1 is taken when Z = 1 (CBZ) or Z = 0 (CBNZ). Taken gives PC_FS = 11, else 01.
  - B.cond: EX0 holds the PC; EX1 evaluates cond = IR[3:0] on live `status`.
- **Condition codes:**
  - 0 Z, 1 ~Z, 2 C, 3 ~C, 4 N, 5 ~N, 6 V, 7 ~V.
  - 8 C&~Z, 9 ~C|Z, 10 N==V, 11 N!=V, 12 ~Z&(N==V), 13 Z|(N!=V).
  - 14 and 15 are always true.
- **ERR:** controlWord all zero (PC held), `done` = `err` = 1, counters unchanged.
- **Counters:**
  - Update in the `done` cycle of legal instructions. B, BL and BR always count as taken.
  - Saturate at all-ones.
  - `clr_cnt` beats a simultaneous increment.

## Timing

- **Reset:** state IDLE, all outputs 0, counters 0. Reset mid-instruction aborts immediately with no further writes.
- **Outputs** are Moore on state, latched IR and live `status`. IR is registered on the `start` edge; later IR changes are ignored.
- **Latency:** BR is 1 cycle (EX0). Others are 2 cycles (EX0, EX1). ERR is 1 cycle.
- **`start` handling:** `start` while busy, including in the `done` cycle, is ignored. The minimum spacing between instructions is one IDLE cycle.
- **CB flags:** CB EX1 sees flags updated at the end of EX0.

## Structure

- **Package `branch_pkg`:** state enum; opcode-class and CB-subop constants; `PC_FS` and `k_mux` encodings; condition-code constants; a control-word packing function parametrised on REG_W.
- **Sub-module `branch_cond_eval`:** combinational, (cond[3:0], status[3:0]) → taken. Reused by any future conditional-select unit.

## Test plan

- **B.NE:** start with IR = 0x5000_0001, status Z = 1. EX0 gives PC_FS = 00 and k_mux = 011; EX1 gives PC_FS = 01 with `done`; nottaken_cnt = 1.
- **BL:** IR[31:29] = 100. EX0 has w_reg = 1, DA = 28, data_tri_sel = 10; EX1 has PC_FS = 11 with `done`; taken_cnt += 1.
- **CBZ with Rt = X5:** EX0 has SA = 31, SB = 5, B_Sel = 0, status_load = 1. Drive Z = 1 into EX1: PC_FS = 11. Repeat as CBNZ: PC_FS = 01.
- **BR:** done in EX0 with PC_FS = 10, PC_sel = 0, k_mux = 000. A `start` pulse in that same cycle is ignored; busy = 0 on the next cycle.
- **Illegal:** IR[31:29] = 111 gives ERR with err = done = 1 for one cycle and controlWord = 0. Also assert `reset` during BL EX0: all outputs 0 asynchronously.
- **Counter saturation:** with CNT_W = 2, run 5 taken B instructions: taken_cnt stays at 3. Then `clr_cnt` together with a 6th done gives 0.
